// File: rtl/filter_seq_pkg.sv
// filter_seq_pkg: shared mode encodings, FSM states, config record and autosweep table
package filter_seq_pkg;
  localparam int CFG_F_W = 19;
  localparam logic [2:0] MODE_LPF = 3'b001;
  localparam logic [2:0] MODE_HPF = 3'b010;
  localparam logic [2:0] MODE_BPF = 3'b100;
  typedef enum logic [1:0] {IDLE, ALIGN, COMMIT, FLUSH} state_t;
  typedef struct packed {
    logic [2:0]         mode;
    logic [CFG_F_W-1:0] f;
    logic               w;
    logic [2:0]         a;
  } cfg_t;
  localparam cfg_t SWEEP_0 = '{mode: MODE_LPF, f: 19'd200,  w: 1'b0, a: 3'b101};
  localparam cfg_t SWEEP_1 = '{mode: MODE_HPF, f: 19'd2000, w: 1'b0, a: 3'b101};
  localparam cfg_t SWEEP_2 = '{mode: MODE_BPF, f: 19'd1020, w: 1'b0, a: 3'b101};
  function automatic cfg_t sweep_entry(input logic [1:0] idx);
    return idx == 2'd0 ? SWEEP_0 : idx == 2'd1 ? SWEEP_1 : SWEEP_2;
  endfunction
endpackage

// File: rtl/filter_seq_tick_cnt.sv
// filter_seq_tick_cnt: sample-tick rising-edge detector and tick counter with clear and terminal-count pulse
module filter_seq_tick_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       smp_tick,
  input  logic       clr,
  input  logic [7:0] target,
  output logic       tick_rise,
  output logic       tc
);
  logic       smp_tick_d;
  logic [7:0] count;
  assign tick_rise = smp_tick & ~smp_tick_d;
  assign tc = tick_rise & (count == target - 8'd1);
  // count sample boundaries; wrap to zero on terminal count so the next phase starts fresh
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_tick_d <= 1'b0;
      count <= 8'd0;
    end else begin
      smp_tick_d <= smp_tick;
      count <= (clr || tc) ? 8'd0 : tick_rise ? count + 8'd1 : count;
    end
  end
endmodule

// File: rtl/filter_cfg_sequencer.sv
// filter_cfg_sequencer: validates config requests, commits them on sample boundaries and mutes dout while the filter flushes; FILTER_SEQ_AUTOSWEEP_EN adds a self-issuing mode sweep
module filter_cfg_sequencer
  import filter_seq_pkg::*;
#(
  parameter int             F_W           = CFG_F_W,
  parameter int             DOUT_W        = 16,
  parameter int             FLUSH_SAMPLES = 32,
  parameter logic [F_W-1:0] F_MIN         = 19'd1,
  parameter logic [F_W-1:0] F_MAX         = 19'd20000,
  parameter logic [2:0]     DEF_MODE      = 3'b001,
  parameter logic [F_W-1:0] DEF_F         = 19'd200,
  parameter logic           DEF_W         = 1'b0,
  parameter logic [2:0]     DEF_A         = 3'b101
`ifdef FILTER_SEQ_AUTOSWEEP_EN
  , parameter int           DWELL_SAMPLES = 160
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef FILTER_SEQ_AUTOSWEEP_EN
  input  logic                     sweep_en,
`endif
  input  logic                     smp_tick,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_mode,
  input  logic [F_W-1:0]           req_f,
  input  logic                     req_w,
  input  logic [2:0]               req_a,
  input  logic signed [DOUT_W-1:0] core_dout,
  output logic [2:0]               mode_sel,
  output logic [F_W-1:0]           f_set,
  output logic                     w_set,
  output logic [2:0]               a_set,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     busy,
  output logic                     cfg_done,
  output logic                     cfg_err
);
  localparam cfg_t DEF_CFG = '{mode: DEF_MODE, f: DEF_F, w: DEF_W, a: DEF_A};
  state_t     state, nxt;
  cfg_t       cur, pend, req, src;
  logic       tick_rise, tc, clr, mute, boot, accept, req_ok, hold, issue;
  logic [7:0] target;
  assign req = '{mode: req_mode, f: req_f, w: req_w, a: req_a};
  assign req_ok = $onehot(req_mode) && req_f >= F_MIN && req_f <= F_MAX && req_a != 3'd0;
  assign req_ready = state == IDLE && !hold;
  assign accept = req_valid && req_ready;
  assign {mode_sel, f_set, w_set, a_set} = cur;
`ifdef FILTER_SEQ_AUTOSWEEP_EN
  logic       sweep_en_d;
  logic [1:0] idx;
  assign hold = sweep_en;
  assign issue = sweep_en && state == IDLE && tc;
  assign src = issue ? sweep_entry(idx) : req;
  assign target = state == IDLE ? 8'(DWELL_SAMPLES) : 8'(FLUSH_SAMPLES);
  assign clr = state == COMMIT || (state == IDLE && !sweep_en);
  // walk the sweep table; restart from the first entry whenever sweeping stops
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_en_d <= 1'b0;
      idx <= 2'd0;
    end else begin
      sweep_en_d <= sweep_en;
      idx <= (sweep_en_d && !sweep_en) ? 2'd0 : issue ? (idx == 2'd2 ? 2'd0 : idx + 2'd1) : idx;
    end
  end
`else
  assign hold = 1'b0;
  assign issue = 1'b0;
  assign src = req;
  assign target = 8'(FLUSH_SAMPLES);
  assign clr = state == COMMIT;
`endif
  filter_seq_tick_cnt u_tick (
    .clk(clk), .rst(rst), .smp_tick(smp_tick), .clr(clr),
    .target(target), .tick_rise(tick_rise), .tc(tc)
  );
  // next state, mute and busy decode
  always_comb begin
    nxt = state;
    mute = state == COMMIT || state == FLUSH;
    busy = state != IDLE;
    nxt = state == IDLE   ? ((issue || (accept && req_ok && req != cur)) ? ALIGN : IDLE) :
          state == ALIGN  ? (tick_rise ? COMMIT : ALIGN) :
          state == COMMIT ? FLUSH :
                            (tc ? IDLE : FLUSH);
  end
  // state, configuration registers, gated output and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FLUSH;
      cur <= DEF_CFG;
      pend <= DEF_CFG;
      dout <= '0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
      boot <= 1'b1;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == ALIGN) pend <= src;
      if (state == ALIGN && tick_rise) cur <= pend;
      dout <= mute ? '0 : core_dout;
      cfg_done <= (state == FLUSH && tc && !boot) || (accept && req_ok && req == cur);
      cfg_err <= accept && !req_ok;
      if (state == FLUSH && tc) boot <= 1'b0;
    end
  end
endmodule
